// File: rtl/twotoone_mux_arbiter.sv
// rtl/twotoone_mux_arbiter.sv - round-robin arbiter driving a registered 2:1 mux
// Grants one of two requesters at a time, bounded hold, one idle cycle between grants.
module twotoone_mux_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic              DONE_A,
  input  logic              DONE_B,
  input  logic [DATA_W-1:0] DIN_A,
  input  logic [DATA_W-1:0] DIN_B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              S,
  output logic [DATA_W-1:0] Z,
  output logic              Z_VALID,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             last_b;
  logic             release_a;
  logic             release_b;

  // Any of owner-done, owner-drop or last permitted cycle ends the grant.
  assign release_a = DONE_A | ~REQ_A | (hold_cnt == HOLD_LAST);
  assign release_b = DONE_B | ~REQ_B | (hold_cnt == HOLD_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_b   <= 1'b1;
      S        <= 1'b0;
      Z        <= '0;
      Z_VALID  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Z_VALID  <= 1'b0;
          hold_cnt <= '0;
          // On a tie the requester that did not own the path last wins.
          if (REQ_A && (!REQ_B || last_b)) begin
            state <= GRANT_A;
            S     <= 1'b0;
          end else if (REQ_B) begin
            state <= GRANT_B;
            S     <= 1'b1;
          end
        end
        GRANT_A: begin
          Z       <= DIN_A;
          Z_VALID <= 1'b1;
          if (release_a) begin
            state    <= IDLE;
            last_b   <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        GRANT_B: begin
          Z       <= DIN_B;
          Z_VALID <= 1'b1;
          if (release_b) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
          Z_VALID  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT_A = (state == GRANT_A);
  assign GNT_B = (state == GRANT_B);
  assign BUSY  = GNT_A | GNT_B;

endmodule

// File: tb/tb_twotoone_mux_arbiter.sv
// tb/tb_twotoone_mux_arbiter.sv - scoreboard bench for twotoone_mux_arbiter
// Driver steps an ownership model per cycle and queues expectations; monitor compares.
module tb_twotoone_mux_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              REQ_A = 1'b0, REQ_B = 1'b0, DONE_A = 1'b0, DONE_B = 1'b0;
  logic [DATA_W-1:0] DIN_A = '0, DIN_B = '0;
  logic              GNT_A, GNT_B, S, Z_VALID, BUSY;
  logic [DATA_W-1:0] Z;

  twotoone_mux_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .DONE_A(DONE_A), .DONE_B(DONE_B), .DIN_A(DIN_A), .DIN_B(DIN_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .S(S), .Z(Z), .Z_VALID(Z_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              ga, gb, s, zv, busy;
    logic [DATA_W-1:0] z;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: owner 0 = nobody, 1 = A, 2 = B; served = cycles owner has had the path.
  int                m_owner = 0;
  int                m_served = 0;
  int                m_last = 2;
  logic              m_s = 1'b0, m_zv = 1'b0;
  logic [DATA_W-1:0] m_z = '0;

  task automatic model_step(input logic rst, ra, rb, da, db,
                            input logic [DATA_W-1:0] a, b);
    int   winner;
    logic own_req, own_done;
    if (rst) begin
      m_owner = 0; m_served = 0; m_last = 2; m_s = 1'b0; m_z = '0; m_zv = 1'b0;
    end else if (m_owner == 0) begin
      m_zv   = 1'b0;
      winner = 0;
      if (ra && rb) winner = (m_last == 1) ? 2 : 1;
      else if (ra)  winner = 1;
      else if (rb)  winner = 2;
      if (winner != 0) begin
        m_owner  = winner;
        m_served = 0;
        m_s      = (winner == 2);
      end
    end else begin
      own_req  = (m_owner == 1) ? ra : rb;
      own_done = (m_owner == 1) ? da : db;
      m_z      = (m_owner == 1) ? a : b;
      m_zv     = 1'b1;
      m_served = m_served + 1;
      if (own_done || !own_req || m_served >= MAX_HOLD) begin
        m_last  = m_owner;
        m_owner = 0;
      end
    end
  endtask

  task automatic tick(input logic rst, ra, rb, da, db,
                      input logic [DATA_W-1:0] a, b);
    exp_t e;
    @(negedge CLK);
    RST = rst; REQ_A = ra; REQ_B = rb; DONE_A = da; DONE_B = db; DIN_A = a; DIN_B = b;
    model_step(rst, ra, rb, da, db, a, b);
    e.ga = (m_owner == 1); e.gb = (m_owner == 2); e.s = m_s;
    e.zv = m_zv; e.busy = (m_owner != 0); e.z = m_z;
    q.push_back(e);
  endtask

  task automatic tick_look(input logic rst, ra, rb, da, db,
                           input logic [DATA_W-1:0] a, b);
    tick(rst, ra, rb, da, db, a, b);
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every edge the DUT presents a fresh output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        expect_val("sb_gnt_s_busy", {GNT_A, GNT_B, S, BUSY}, {e.ga, e.gb, e.s, e.busy});
        expect_val("sb_z_valid", Z_VALID, e.zv);
        expect_val("sb_z", Z, e.z);
        expect_val("inv_mutex", GNT_A & GNT_B, 1'b0);
        expect_val("inv_sel", (GNT_A & S) | (GNT_B & ~S), 1'b0);
      end
    end
  end

  initial begin
    int na, nb;
    logic r_rst, r_ra, r_rb, r_da, r_db;

    // Reset held with a request pending.
    tick_look(1, 1, 0, 0, 0, 8'h11, 8'h22);
    expect_val("rst1_outs", {GNT_A, GNT_B, S, Z_VALID, BUSY, Z}, '0);
    tick_look(1, 1, 0, 0, 0, 8'h11, 8'h22);
    expect_val("rst2_outs", {GNT_A, GNT_B, S, Z_VALID, BUSY, Z}, '0);

    // Single requester A, released by DONE_A.
    tick_look(0, 1, 0, 0, 0, 8'h5A, 8'h00);
    expect_val("a_grant", {GNT_A, S, Z_VALID}, 3'b100);
    tick_look(0, 1, 0, 0, 0, 8'h5A, 8'h00);
    expect_val("a_z", {Z_VALID, Z}, {1'b1, 8'h5A});
    tick_look(0, 1, 0, 1, 0, 8'h5A, 8'h00);
    expect_val("a_done_rel", {GNT_A, Z_VALID}, 2'b01);
    tick_look(0, 0, 0, 0, 0, 8'h5A, 8'h00);
    expect_val("a_zv_drop", {Z_VALID, Z}, {1'b0, 8'h5A});

    // Single requester B, released by dropping REQ_B.
    tick_look(0, 0, 1, 0, 0, 8'h00, 8'hC3);
    expect_val("b_grant", {GNT_B, S}, 2'b11);
    tick_look(0, 0, 1, 0, 0, 8'h00, 8'hC3);
    expect_val("b_z", Z, 8'hC3);
    tick_look(0, 0, 0, 0, 0, 8'h00, 8'hC3);
    expect_val("b_drop_rel", GNT_B, 1'b0);

    // DONE_B while A owns: ignored, A runs to timeout.
    na = 0;
    for (int i = 0; i < 5; i++) begin
      tick_look(0, 1, 0, 0, (i == 2), 8'h40 + 8'(i), 8'h00);
      na += int'(GNT_A);
    end
    expect_val("a_timeout_len", na, MAX_HOLD);
    tick_look(0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Both held: alternating MAX_HOLD-cycle grants with one idle between.
    na = 0; nb = 0;
    for (int i = 0; i < 2 * (MAX_HOLD + 1) * 2; i++) begin
      tick_look(0, 1, 1, 0, 0, 8'hA0 + 8'(i), 8'hB0 + 8'(i));
      na += int'(GNT_A);
      nb += int'(GNT_B);
    end
    expect_val("rr_cnt_a", na, 2 * MAX_HOLD);
    expect_val("rr_cnt_b", nb, 2 * MAX_HOLD);
    tick_look(0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Reset mid GRANT_B, then a tie goes to A.
    tick_look(0, 0, 1, 0, 0, 8'h00, 8'h77);
    tick_look(0, 0, 1, 0, 0, 8'h00, 8'h77);
    expect_val("pre_rst_b", {GNT_B, Z}, {1'b1, 8'h77});
    tick_look(1, 1, 1, 0, 0, 8'h00, 8'h77);
    expect_val("mid_rst_outs", {GNT_A, GNT_B, S, Z_VALID, BUSY, Z}, '0);
    tick_look(0, 1, 1, 0, 0, 8'h33, 8'h77);
    expect_val("post_rst_tie", {GNT_A, GNT_B}, 2'b10);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_ra  = ($urandom_range(0, 3) != 0);
      r_rb  = ($urandom_range(0, 3) != 0);
      r_da  = ($urandom_range(0, 7) == 0);
      r_db  = ($urandom_range(0, 7) == 0);
      tick(r_rst, r_ra, r_rb, r_da, r_db, DATA_W'($urandom), DATA_W'($urandom));
    end

    tick(0, 0, 0, 0, 0, 8'h00, 8'h00);
    repeat (3) @(posedge CLK);
    #2;
    expect_val("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
